// File: rtl/matmul_row_ctrl_pkg.sv
// rtl/matmul_row_ctrl_pkg.sv - shared types and constants for the row MAC sequencer
//   Holds the sequencer state encoding, engine geometry (lanes, element and
//   row widths) and the default engine-result timeout.
package matmul_row_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4
  } state_e;

  localparam int DIM         = 8;
  localparam int ELEM_W      = 8;
  localparam int ROW_W       = 64;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/matmul_row_ctrl.sv
// rtl/matmul_row_ctrl.sv - sequencer feeding A/B operands to the 8-lane MAC engine
//   Ports:
//     clk_i, rstn_i              clock, asynchronous active-low reset
//     start_i / busy_o / done_o  job start, job in progress, end-of-job pulse
//     err_o                      sticky engine timeout, cleared on accepted start
//     a_rd_o/a_addr_o/a_data_i   A buffer read (row*8+k), data one cycle later
//     b_rd_o/b_addr_o/b_data_i   B buffer read (row k), data one cycle later
//     eng_*_o                    enable, beat valid, A scalar and B row to engine
//     eng_valid_i/eng_result_i   engine result pulse, result row on next cycle
//     c_wr_o/c_addr_o/c_data_o   result write request held until c_ready_i
module matmul_row_ctrl
  import matmul_row_ctrl_pkg::*;
#(
  parameter int M       = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              a_rd_o,
  output logic [5:0]        a_addr_o,
  input  logic [ELEM_W-1:0] a_data_i,
  output logic              b_rd_o,
  output logic [2:0]        b_addr_o,
  input  logic [ROW_W-1:0]  b_data_i,
  output logic              eng_en_o,
  output logic              eng_valid_o,
  output logic [ELEM_W-1:0] eng_din1_o,
  output logic [ROW_W-1:0]  eng_din2_o,
  input  logic              eng_valid_i,
  input  logic [ROW_W-1:0]  eng_result_i,
  output logic              c_wr_o,
  output logic [2:0]        c_addr_o,
  output logic [ROW_W-1:0]  c_data_o,
  input  logic              c_ready_i
);

  localparam int ROW_CW = (M > 1) ? $clog2(M) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [ROW_CW-1:0]   row_q, row_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                ev_q, ev_d;
  logic [2:0]          c_addr_q, c_addr_d;
  logic [ROW_W-1:0]    c_data_q, c_data_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      row_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ev_q     <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      row_q    <= row_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ev_q     <= ev_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    row_d    = row_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    done_d   = 1'b0;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    // A read issued this cycle returns data next cycle; that cycle carries the beat.
    ev_d     = (state_q == ST_ISSUE);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          row_d   = '0;
          k_d     = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'(DIM - 1)) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (eng_valid_i) begin
          state_d = ST_CAPTURE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CAPTURE: begin
        c_data_d = eng_result_i;
        c_addr_d = 3'(row_q);
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        if (c_ready_i) begin
          if (row_q == ROW_CW'(M - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + ROW_CW'(1);
            k_d     = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign a_rd_o      = (state_q == ST_ISSUE);
  assign b_rd_o      = (state_q == ST_ISSUE);
  assign a_addr_o    = {3'(row_q), k_q};
  assign b_addr_o    = k_q;
  assign eng_en_o    = busy_o;
  // The buffer outputs are already registered, so the beat is forwarded in the
  // cycle the data appears; gating by ev_q drops stale data after reset or a row.
  assign eng_valid_o = ev_q;
  assign eng_din1_o  = ev_q ? a_data_i : '0;
  assign eng_din2_o  = ev_q ? b_data_i : '0;
  assign c_wr_o      = (state_q == ST_WRITE);
  assign c_addr_o    = c_addr_q;
  assign c_data_o    = c_data_q;

endmodule

// File: tb/tb_matmul_row_ctrl.sv
// tb/tb_matmul_row_ctrl.sv - scoreboard bench for matmul_row_ctrl with buffer and engine models
module tb_matmul_row_ctrl;

  localparam int M = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic        a_rd_o, b_rd_o;
  logic [5:0]  a_addr_o;
  logic [2:0]  b_addr_o;
  logic [7:0]  a_data_i = '0;
  logic [63:0] b_data_i = '0;
  logic        eng_en_o, eng_valid_o;
  logic [7:0]  eng_din1_o;
  logic [63:0] eng_din2_o;
  logic        eng_valid_i = 1'b0;
  logic [63:0] eng_result_i = '0;
  logic        c_wr_o;
  logic [2:0]  c_addr_o;
  logic [63:0] c_data_o;
  logic        c_ready_i = 1'b1;

  matmul_row_ctrl #(.M(M), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .a_rd_o(a_rd_o), .a_addr_o(a_addr_o), .a_data_i(a_data_i),
    .b_rd_o(b_rd_o), .b_addr_o(b_addr_o), .b_data_i(b_data_i),
    .eng_en_o(eng_en_o), .eng_valid_o(eng_valid_o),
    .eng_din1_o(eng_din1_o), .eng_din2_o(eng_din2_o),
    .eng_valid_i(eng_valid_i), .eng_result_i(eng_result_i),
    .c_wr_o(c_wr_o), .c_addr_o(c_addr_o), .c_data_o(c_data_o),
    .c_ready_i(c_ready_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  a_mem [64];
  logic [63:0] b_mem [8];
  bit          eng_mute = 1'b0;
  bit          rand_bp = 1'b0;
  int          bp_left = 0;
  bit          bp_check = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  logic [66:0] exp_q [$];
  bit          done_exp [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operand buffers: registered read, data visible the cycle after the strobe.
  always @(posedge clk_i) begin
    if (a_rd_o) a_data_i <= a_mem[a_addr_o];
    if (b_rd_o) b_data_i <= b_mem[b_addr_o];
  end

  // Engine: 8-lane MAC, result pulse 3 cycles after the 8th beat, row on the next cycle.
  logic [31:0] acc [8];
  int beats = 0;
  int lat = 0;
  always @(posedge clk_i) begin
    eng_valid_i <= 1'b0;
    if (eng_valid_i) begin
      for (int l = 0; l < 8; l++) eng_result_i[l*8 +: 8] <= acc[l][7:0];
      for (int l = 0; l < 8; l++) acc[l] = 0;
    end
    if (!rstn_i || !eng_en_o) begin
      beats = 0;
      lat = 0;
      for (int l = 0; l < 8; l++) acc[l] = 0;
    end else if (eng_valid_o) begin
      for (int l = 0; l < 8; l++) acc[l] = acc[l] + 32'(eng_din1_o) * 32'(eng_din2_o[l*8 +: 8]);
      beats++;
      if (beats == 8) begin
        beats = 0;
        lat = 3;
      end
    end else if (lat > 0) begin
      lat--;
      if (lat == 0 && !eng_mute) eng_valid_i <= 1'b1;
    end
  end

  // Result buffer ready, changed shortly after the active edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (bp_left > 0 && c_wr_o && c_addr_o == 3'd2) begin
        c_ready_i = 1'b0;
        bp_left--;
      end else if (rand_bp) begin
        c_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        c_ready_i = 1'b1;
      end
    end
  end

  function automatic logic [63:0] ref_row(input int r);
    logic [63:0] res;
    int s;
    for (int lane = 0; lane < 8; lane++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += int'(a_mem[r*8 + k]) * int'(b_mem[k][lane*8 +: 8]);
      res[lane*8 +: 8] = 8'(s);
    end
    return res;
  endfunction

  // Monitor / scoreboard.
  bit          prev_stall = 1'b0;
  logic [2:0]  prev_addr;
  logic [63:0] prev_data;
  int          stall_cnt = 0;
  initial begin
    logic [66:0] e;
    bit eerr;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rstn_i) begin
        prev_stall = 1'b0;
        stall_cnt = 0;
      end else begin
        if (prev_stall) begin
          check("hold_wr", c_wr_o, 1);
          check("hold_addr", c_addr_o, prev_addr);
          check("hold_data", c_data_o, prev_data);
        end
        if (c_wr_o) check("no_read_during_write", a_rd_o, 0);
        if (c_wr_o && c_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("c_addr", c_addr_o, e[66:64]);
            check("c_data", c_data_o, e[63:0]);
            if (bp_check && c_addr_o == 3'd2) check("bp_stall_cycles", stall_cnt, 5);
          end
          stall_cnt = 0;
        end else if (c_wr_o) begin
          stall_cnt++;
        end
        prev_stall = c_wr_o && !c_ready_i;
        prev_addr = c_addr_o;
        prev_data = c_data_o;
        if (a_rd_o) last_rd_cyc = cyc;
        if (done_o) begin
          if (done_exp.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            eerr = done_exp.pop_front();
            check("done_err", err_o, eerr);
            check("done_busy_low", busy_o, 0);
            check("rows_left_at_done", exp_q.size(), 0);
            if (eerr) check("timeout_latency", cyc - last_rd_cyc, 65);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic push_job(input bit tmo);
    if (!tmo) for (int r = 0; r < M; r++) exp_q.push_back({3'(r), ref_row(r)});
    done_exp.push_back(tmo);
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("err_cleared_on_start", err_o, 0);
  endtask

  task automatic run_job(input bit tmo, input bit bp2, input bit rbp, input bit extra);
    int d0;
    int budget;
    bp_check = bp2;
    bp_left = bp2 ? 5 : 0;
    rand_bp = rbp;
    push_job(tmo);
    d0 = done_cnt;
    pulse_start();
    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      @(negedge clk_i);
      budget++;
      start_i = 1'b0;
      if (extra && busy_o && $urandom_range(0, 7) == 0) start_i = 1'b1;
    end
    start_i = 1'b0;
    if (done_cnt == d0) begin
      check("job_completion", 0, 1);
      exp_q.delete();
      done_exp.delete();
    end
    repeat (3) @(negedge clk_i);
    check("single_done", done_cnt - d0, 1);
    rand_bp = 1'b0;
    bp_check = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {busy_o, done_o, err_o, a_rd_o, a_addr_o, b_rd_o, b_addr_o,
                           eng_en_o, eng_valid_o, c_wr_o, c_addr_o}, 0);
    check({tag, "_din1"}, eng_din1_o, 0);
    check({tag, "_din2"}, eng_din2_o, 0);
    check({tag, "_cdata"}, c_data_o, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) a_mem[i] = 8'($urandom);
    for (int k = 0; k < 8; k++) b_mem[k] = {$urandom, $urandom};
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 64; i++) a_mem[i] = 8'(i);
    for (int k = 0; k < 8; k++) b_mem[k] = 64'hFF << (8 * k) & 64'h0101_0101_0101_0101;
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);
    check_zero("idle");

    // Identity: C row r equals A row r.
    run_job(1'b0, 1'b0, 1'b0, 1'b0);

    // Accumulator wrap.
    for (int i = 0; i < 64; i++) a_mem[i] = 8'd2;
    for (int k = 0; k < 8; k++) b_mem[k] = {8{8'h10}};
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) a_mem[i] = 8'd3;
    for (int k = 0; k < 8; k++) b_mem[k] = {8{8'h11}};
    run_job(1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure on row 2.
    fill_random();
    run_job(1'b0, 1'b1, 1'b0, 1'b0);

    // Engine never answers, then a clean job clears err_o.
    eng_mute = 1'b1;
    run_job(1'b1, 1'b0, 1'b0, 1'b0);
    check("err_sticky", err_o, 1);
    eng_mute = 1'b0;
    fill_random();
    run_job(1'b0, 1'b0, 1'b0, 1'b0);
    check("err_after_clean_job", err_o, 0);

    // Starts while busy are ignored, with random backpressure.
    fill_random();
    run_job(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of row 4 issue.
    fill_random();
    push_job(1'b0);
    pulse_start();
    budget = 0;
    while (!(a_rd_o && a_addr_o == 6'd35) && budget < 2000) begin
      @(negedge clk_i);
      budget++;
    end
    check("reach_row4_issue", a_addr_o, 6'd35);
    rstn_i = 1'b0;
    #1;
    check_zero("midjob_reset");
    exp_q.delete();
    done_exp.delete();
    @(negedge clk_i);
    check_zero("midjob_reset_edge");
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("no_write_after_reset", c_wr_o, 0);
    fill_random();
    run_job(1'b0, 1'b0, 1'b0, 1'b0);

    // A few more random jobs.
    for (int j = 0; j < 3; j++) begin
      fill_random();
      run_job(1'b0, 1'b0, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
